arm_pose_sequencer: RTL and testbench
=====================================

Name: arm_pose_sequencer

Overview:
Plays back a stored table of arm poses across NUM_JOINTS servo channels. For each pose it drives every joint's DESIRED word and waits until all joint FLAGs report arrival. It then dwells for a programmed time and advances to the next pose. It sits between the host/command logic and the per-joint Servo PWM blocks, consuming their FLAG outputs and driving their DESIRED inputs.

Parameters:
NUM_JOINTS, 4, number of servo channels driven
POSES, 8, pose table depth (power of 2)
POS_W, 20, width of one joint position word (matches Servo DESIRED)
DWELL_W, 27, width of dwell counter
GUARD, 4, cycles ignored after a new pose is loaded (covers registered-FLAG lag)
TIMEOUT, 50_000_000, max CLK cycles allowed in MOVE before error
HOME_POS, 75_000, per-joint DESIRED value at reset

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
START  in  1  begin playback from pose 0 (sampled in IDLE only)
ABORT  in  1  stop playback, hold current DESIRED
LOOP  in  1  1 = wrap to pose 0 after last pose instead of finishing
NUM_POSES  in  log2(POSES)+1  poses to play, latched at START
DWELL  in  DWELL_W  dwell cycles per pose, latched at START
WR_EN  in  1  pose table write strobe
WR_ADDR  in  log2(POSES)  pose index to write
WR_JOINT  in  log2(NUM_JOINTS)  joint index to write
WR_DATA  in  POS_W  position word
FLAGS  in  NUM_JOINTS  per-joint arrived flags from Servo blocks
DESIRED  out  NUM_JOINTS*POS_W  flattened targets; joint j at [j*POS_W +: POS_W]
POSE_IDX  out  log2(POSES)  pose currently commanded
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse on normal completion
TIMEOUT_ERR  out  1  sticky error flag

Behaviour:
- Only one clock and one reset: CLK, with RST synchronous and active-high.
- Reset values:
  - every DESIRED joint = HOME_POS
  - POSE_IDX = 0, BUSY = 0, DONE = 0, TIMEOUT_ERR = 0
  - state = IDLE
  - pose table contents are not reset (undefined until written)
- Table writes: WR_EN writes WR_DATA to table[WR_ADDR][WR_JOINT] at the edge. Writes are accepted in any state. A write affects outputs only when that pose is next loaded. DESIRED is never altered directly by a write.
- States: IDLE, LOAD, GUARD, MOVE, DWELL, NEXT.
- IDLE:
  - START=1 and clamped NUM_POSES != 0 → LOAD. Latch the clamped NUM_POSES (values > POSES clamp to POSES) and DWELL. Set POSE_IDX=0 and clear TIMEOUT_ERR.
  - START with NUM_POSES=0 is ignored.
- LOAD (1 cycle): DESIRED ← table[POSE_IDX] for all joints, registered at the exit edge. Load guard counter with GUARD. → GUARD.
- GUARD: count down GUARD cycles; FLAGS are ignored. At 0 → MOVE and clear the timeout counter.
- MOVE:
  - &FLAGS==1 → DWELL with the counter loaded from latched DWELL. If DWELL==0, go straight to NEXT.
  - Otherwise increment the timeout counter. On reaching TIMEOUT: set TIMEOUT_ERR, → IDLE, hold DESIRED.
- DWELL: count down. At reaching 0 → NEXT. DWELL=n gives exactly n cycles in DWELL.
- NEXT (1 cycle):
  - POSE_IDX < latched NUM_POSES-1: increment POSE_IDX, → LOAD.
  - Last pose, LOOP=1: POSE_IDX=0, → LOAD.
  - Last pose, LOOP=0: DONE=1 for this single cycle, → IDLE, POSE_IDX holds last index.
- ABORT: from any non-IDLE state → IDLE at the next edge. DESIRED, POSE_IDX and TIMEOUT_ERR hold; no DONE pulse. ABORT beats START in the same cycle. ABORT in IDLE has no effect.
- START while BUSY is ignored.
- LOOP is sampled only in NEXT, so it may change during playback.
- RST mid-playback: all outputs return to reset values at that edge. Servos then slew to HOME_POS.
- Latency: START at edge k → BUSY=1 after edge k; pose-0 DESIRED valid after edge k+1. With all FLAGS already high, minimum per-pose period is 1+GUARD+1+DWELL+1 cycles.

Test Plan:
1. Reset, write 2 poses (pose0 joints = 1000/2000/3000/4000, pose1 = 500 each). Set NUM_POSES=2, DWELL=10, LOOP=0, FLAGS tied high. Pulse START → DESIRED=pose0 one edge after LOAD; pose1 follows 1+4+1+10+1 cycles later; DONE pulses once; BUSY falls on the same edge DONE rises.
2. FLAGS model driven by Servo instances with SLK=CLK/4 → MOVE exits only when all four joints arrive; a GUARD-window FLAG=1 left over from the prior pose must not advance the state.
3. TIMEOUT=1000 bench param, FLAGS[2] held low → TIMEOUT_ERR=1 after 1000 MOVE cycles, state IDLE, DESIRED holds pose0; next START clears TIMEOUT_ERR.
4. LOOP=1, NUM_POSES=3 → POSE_IDX sequence 0,1,2,0,1; assert ABORT mid-DWELL of pose 1 → BUSY=0 next edge, DESIRED=pose1, no DONE.
5. Boundaries: START with NUM_POSES=0 → ignored. NUM_POSES=15 → clamps to 8 poses. DWELL=0 → MOVE→NEXT directly. START and ABORT both high in IDLE → stays IDLE.
6. RST asserted during MOVE → DESIRED all = 75000, POSE_IDX=0, BUSY=0. Writing table[current pose] during DWELL → DESIRED unchanged until reloaded.

Source files
------------

// File: rtl/arm_pose_sequencer.sv
// Pose-table playback sequencer: drives every joint's DESIRED word for one pose, waits for all
// joints to arrive, dwells, then advances. It stops on completion, ABORT, or a MOVE timeout.
module arm_pose_sequencer #(
    parameter int NUM_JOINTS = 4,
    parameter int POSES      = 8,
    parameter int POS_W      = 20,
    parameter int DWELL_W    = 27,
    parameter int GUARD      = 4,
    parameter int TIMEOUT    = 50_000_000,
    parameter int HOME_POS   = 75_000
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic                            ABORT,
    input  logic                            LOOP,
    input  logic [$clog2(POSES):0]          NUM_POSES,
    input  logic [DWELL_W-1:0]              DWELL,
    input  logic                            WR_EN,
    input  logic [$clog2(POSES)-1:0]        WR_ADDR,
    input  logic [$clog2(NUM_JOINTS)-1:0]   WR_JOINT,
    input  logic [POS_W-1:0]                WR_DATA,
    input  logic [NUM_JOINTS-1:0]           FLAGS,
    output logic [NUM_JOINTS*POS_W-1:0]     DESIRED,
    output logic [$clog2(POSES)-1:0]        POSE_IDX,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            TIMEOUT_ERR,
    output logic [2:0]                      STATE_DBG
);
    localparam int IDX_W = $clog2(POSES);
    localparam int NP_W  = IDX_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GUARD, S_MOVE, S_DWELL, S_NEXT} state_t;

    logic [POS_W-1:0] table_mem [POSES][NUM_JOINTS];

    state_t                      state_q, state_d;
    logic [NUM_JOINTS*POS_W-1:0] desired_q, desired_d;
    logic [IDX_W-1:0]            pose_idx_q, pose_idx_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic [NP_W-1:0]             num_poses_q, num_poses_d;
    logic [DWELL_W-1:0]          dwell_q, dwell_d;
    logic [DWELL_W-1:0]          cnt_q, cnt_d;
    logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
    logic [NP_W-1:0]             np_clamped;
    logic                        last_pose;

    // Table storage is not reset; contents are only meaningful once written.
    always_ff @(posedge CLK) begin
        if (WR_EN) begin
            table_mem[WR_ADDR][WR_JOINT] <= WR_DATA;
        end
    end

    always_comb begin
        np_clamped = (NUM_POSES > NP_W'(POSES)) ? NP_W'(POSES) : NUM_POSES;
        last_pose  = ({1'b0, pose_idx_q} == (num_poses_q - NP_W'(1)));

        state_d     = state_q;
        desired_d   = desired_q;
        pose_idx_d  = pose_idx_q;
        done_d      = 1'b0;
        err_d       = err_q;
        num_poses_d = num_poses_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        to_cnt_d    = to_cnt_q;

        if (ABORT && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START && !ABORT && (np_clamped != '0)) begin
                        state_d     = S_LOAD;
                        num_poses_d = np_clamped;
                        dwell_d     = DWELL;
                        pose_idx_d  = '0;
                        err_d       = 1'b0;
                    end
                end
                S_LOAD: begin
                    for (int j = 0; j < NUM_JOINTS; j++) begin
                        desired_d[j*POS_W +: POS_W] = table_mem[pose_idx_q][j];
                    end
                    cnt_d   = DWELL_W'(GUARD);
                    state_d = S_GUARD;
                end
                S_GUARD: begin
                    // FLAGS may still reflect the previous pose here, so they are not looked at.
                    if (cnt_q <= DWELL_W'(1)) begin
                        state_d  = S_MOVE;
                        to_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                S_MOVE: begin
                    if (&FLAGS) begin
                        if (dwell_q == '0) begin
                            state_d = S_NEXT;
                        end else begin
                            state_d = S_DWELL;
                            cnt_d   = dwell_q;
                        end
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                S_DWELL: begin
                    if (cnt_q <= DWELL_W'(1)) begin
                        state_d = S_NEXT;
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                S_NEXT: begin
                    if (!last_pose) begin
                        pose_idx_d = pose_idx_q + IDX_W'(1);
                        state_d    = S_LOAD;
                    end else if (LOOP) begin
                        pose_idx_d = '0;
                        state_d    = S_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            desired_q   <= {NUM_JOINTS{POS_W'(HOME_POS)}};
            pose_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            num_poses_q <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            desired_q   <= desired_d;
            pose_idx_q  <= pose_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            num_poses_q <= num_poses_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign DESIRED     = desired_q;
    assign POSE_IDX    = pose_idx_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign TIMEOUT_ERR = err_q;
    assign STATE_DBG   = state_q;
endmodule

// File: tb/tb_arm_pose_sequencer.sv
// Bench for arm_pose_sequencer: a servo-like FLAGS model with random arrival delays and an
// event-timeline reference model that predicts load/DONE times from per-pose period arithmetic.
module tb_arm_pose_sequencer;
    localparam int NJ   = 4;
    localparam int NP   = 8;
    localparam int PW   = 20;
    localparam int G    = 4;
    localparam int TO   = 1000;
    localparam int HOME = 75000;
    localparam int S    = 2;   // cycles a stale FLAG stays high after a new target appears

    logic           clk = 1'b0;
    logic           rst, start, abort, loop_i, wr_en;
    logic [3:0]     num_poses;
    logic [26:0]    dwell;
    logic [2:0]     wr_addr;
    logic [1:0]     wr_joint;
    logic [19:0]    wr_data;
    logic [NJ-1:0]  flags = '1;
    logic [79:0]    desired;
    logic [2:0]     pose_idx;
    logic           busy, done, terr;
    logic [2:0]     state_dbg;

    logic [PW-1:0]  model_tab [NP][NJ];
    int             cyc = 0;
    int             ld_cyc_q[$];
    logic [79:0]    ld_val_q[$];
    logic [2:0]     ld_idx_q[$];
    int             ld_dmax_q[$];
    int             done_q[$];
    int             fall_q[$];
    int             stale_end = 0;
    int             arrive [NJ] = '{default: 0};
    int             max_delay = 12;
    logic [NJ-1:0]  force_low = '0;
    logic [79:0]    prev_des = 'x;
    logic           prev_busy = 1'b0;
    int             tests = 0;
    int             fails = 0;

    arm_pose_sequencer #(.TIMEOUT(TO)) dut (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .LOOP(loop_i),
        .NUM_POSES(num_poses), .DWELL(dwell), .WR_EN(wr_en), .WR_ADDR(wr_addr),
        .WR_JOINT(wr_joint), .WR_DATA(wr_data), .FLAGS(flags), .DESIRED(desired),
        .POSE_IDX(pose_idx), .BUSY(busy), .DONE(done), .TIMEOUT_ERR(terr),
        .STATE_DBG(state_dbg)
    );

    always #5 clk = ~clk;

    // Monitor and servo model: log every new target and re-arm per-joint arrival times.
    always @(posedge clk) begin
        int dm;
        int d;
        #1;
        cyc = cyc + 1;
        if (desired !== prev_des) begin
            dm = 0;
            for (int j = 0; j < NJ; j++) begin
                d = $urandom_range(0, max_delay);
                arrive[j] = cyc + S + d;
                if (d > dm) dm = d;
            end
            stale_end = cyc + S;
            ld_cyc_q.push_back(cyc);
            ld_val_q.push_back(desired);
            ld_idx_q.push_back(pose_idx);
            ld_dmax_q.push_back(dm);
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (prev_busy === 1'b1 && busy === 1'b0) fall_q.push_back(cyc);
        prev_des  = desired;
        prev_busy = busy;
        for (int j = 0; j < NJ; j++) begin
            flags[j] = !force_low[j] && ((cyc < stale_end) || (cyc >= arrive[j]));
        end
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [79:0] pack(input int p);
        logic [79:0] v;
        for (int j = 0; j < NJ; j++) v[j*PW +: PW] = model_tab[p][j];
        return v;
    endfunction

    function automatic logic [79:0] home_vec();
        logic [79:0] v;
        for (int j = 0; j < NJ; j++) v[j*PW +: PW] = 20'(HOME);
        return v;
    endfunction

    task automatic write_word(input int p, input int j, input logic [19:0] v);
        wr_en    = 1'b1;
        wr_addr  = 3'(p);
        wr_joint = 2'(j);
        wr_data  = v;
        model_tab[p][j] = v;
        tick();
        wr_en = 1'b0;
    endtask

    // Every pose gets distinct values per joint so each load visibly changes DESIRED.
    task automatic fill_table();
        for (int p = 0; p < NP; p++) begin
            for (int j = 0; j < NJ; j++) begin
                write_word(p, j, {3'(p), 2'(j), 15'($urandom)});
            end
        end
    endtask

    task automatic clear_logs();
        ld_cyc_q.delete(); ld_val_q.delete(); ld_idx_q.delete(); ld_dmax_q.delete();
        done_q.delete(); fall_q.delete();
    endtask

    task automatic play(input int np, input int dw, input logic lp, output int s);
        clear_logs();
        num_poses = 4'(np);
        dwell     = 27'(dw);
        loop_i    = lp;
        start     = 1'b1;
        s         = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_expired", (n >= budget), 0);
    endtask

    task automatic wait_loads(input int want, input int budget);
        int n;
        n = 0;
        while (ld_cyc_q.size() < want && n < budget) begin
            tick();
            n++;
        end
        check("wait_loads_expired", (n >= budget), 0);
    endtask

    // Reference timeline: pose k loads at e; MOVE clears at m = max(e+GUARD, last arrival);
    // the next load lands at m+dwell+3 and completion is seen at m+dwell+2.
    task automatic check_run(input int s, input int npe, input int dw, input int n_exp,
                             input bit done_exp);
        int e, m, e_end, idx;
        e = s + 2;
        e_end = 0;
        check("n_loads", ld_cyc_q.size(), n_exp);
        for (int k = 0; k < n_exp && k < ld_cyc_q.size(); k++) begin
            idx = k % npe;
            check($sformatf("ld%0d_cyc", k), ld_cyc_q[k], e);
            check($sformatf("ld%0d_idx", k), ld_idx_q[k], idx);
            check($sformatf("ld%0d_val", k), ld_val_q[k], pack(idx));
            m = (e + G > e + S + ld_dmax_q[k]) ? e + G : e + S + ld_dmax_q[k];
            e_end = m + dw + 2;
            e = m + dw + 3;
        end
        if (done_exp) begin
            check("done_count", done_q.size(), 1);
            if (done_q.size() > 0) check("done_cyc", done_q[0], e_end);
            check("busy_fall_count", fall_q.size(), 1);
            if (fall_q.size() > 0) check("busy_fall_cyc", fall_q[0], e_end);
        end
    endtask

    initial begin
        int s, np, dw, m4, e0;
        logic [79:0] old;
        rst = 1'b1; start = 1'b0; abort = 1'b0; loop_i = 1'b0; num_poses = '0; dwell = '0;
        wr_en = 1'b0; wr_addr = '0; wr_joint = '0; wr_data = '0;
        repeat (3) tick();
        check("rst_desired", desired, home_vec());
        check("rst_pose_idx", pose_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_terr", terr, 0);
        rst = 1'b0;
        tick();

        // Two fixed poses, FLAGS arriving immediately.
        write_word(0, 0, 1000); write_word(0, 1, 2000); write_word(0, 2, 3000); write_word(0, 3, 4000);
        for (int j = 0; j < NJ; j++) write_word(1, j, 500);
        max_delay = 0;
        play(2, 10, 1'b0, s);
        wait_idle(300);
        check_run(s, 2, 10, 2, 1);
        check("t1_pose_idx_holds", pose_idx, 1);

        // Randomized playbacks with random servo arrival, including NUM_POSES clamping and DWELL=0.
        max_delay = 12;
        for (int r = 0; r < 6; r++) begin
            fill_table();
            np = (r == 0) ? 15 : $urandom_range(1, 12);
            dw = (r == 1) ? 0 : $urandom_range(0, 6);
            play(np, dw, 1'b0, s);
            wait_idle(1500);
            check_run(s, (np > NP) ? NP : np, dw, (np > NP) ? NP : np, 1);
        end

        // MOVE timeout with one joint never arriving.
        fill_table();
        force_low = 4'b0100;
        play(1, 0, 1'b0, s);
        wait_idle(TO + 100);
        check("to_n_loads", ld_cyc_q.size(), 1);
        check("to_fall_count", fall_q.size(), 1);
        if (fall_q.size() > 0) check("to_fall_cyc", fall_q[0], s + 2 + G + TO);
        check("to_err", terr, 1);
        check("to_desired_holds", desired, pack(0));
        check("to_no_done", done_q.size(), 0);
        force_low = '0;
        play(1, 0, 1'b0, s);
        check("to_err_cleared", terr, 0);
        check("to_restart_busy", busy, 1);
        wait_idle(200);
        check("to_restart_done", done_q.size(), 1);

        // LOOP with three poses, then ABORT in the middle of pose 1's dwell.
        fill_table();
        play(3, 10, 1'b1, s);
        wait_loads(5, 400);
        check_run(s, 3, 10, 5, 0);
        m4 = (ld_cyc_q[4] + G > ld_cyc_q[4] + S + ld_dmax_q[4]) ?
             ld_cyc_q[4] + G : ld_cyc_q[4] + S + ld_dmax_q[4];
        while (cyc < m4 + 3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_desired", desired, pack(1));
        check("abort_pose_idx", pose_idx, 1);
        repeat (5) tick();
        check("abort_no_done", done_q.size(), 0);
        check("abort_no_reload", ld_cyc_q.size(), 5);

        // START with NUM_POSES=0, and START together with ABORT, both stay idle.
        play(0, 3, 1'b0, s);
        repeat (4) tick();
        check("np0_busy", busy, 0);
        check("np0_no_load", ld_cyc_q.size(), 0);
        clear_logs();
        num_poses = 4'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check("start_abort_busy", busy, 0);
        check("start_abort_no_load", ld_cyc_q.size(), 0);

        // Reset while stuck in MOVE on pose 1.
        fill_table();
        play(3, 2, 1'b0, s);
        wait_loads(2, 200);
        force_low = 4'b0001;
        repeat (G + 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        force_low = '0;
        check("rstmid_desired", desired, home_vec());
        check("rstmid_pose_idx", pose_idx, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        tick();

        // Rewriting the current pose during DWELL only shows up at the next load.
        fill_table();
        max_delay = 0;
        play(1, 30, 1'b1, s);
        wait_loads(1, 50);
        e0 = s + 2;
        while (cyc < e0 + G + 5) tick();
        old = pack(0);
        for (int j = 0; j < NJ; j++) write_word(0, j, model_tab[0][j] ^ 20'h00001);
        check("wr_dwell_desired_holds", desired, old);
        wait_loads(2, 100);
        if (ld_cyc_q.size() > 1) begin
            check("wr_reload_cyc", ld_cyc_q[1], e0 + G + 30 + 3);
            check("wr_reload_val", ld_val_q[1], pack(0));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("wr_abort_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
